// File: rtl/mips_mc_pkg.sv
// mips_mc_pkg
// Shared encodings for the multi-cycle MIPS controller: opcode and funct
// constants, ALU control codes, mux select codes and the 4-bit FSM state
// codes. Imported by mips_mc_aludec and mips_mc_controller.
// Optional feature macro used by the controller: MIPS_MC_JUMP_EN.

package mips_mc_pkg;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_ctl_t;

  typedef enum logic [1:0] {
    SRCB_B      = 2'b00,
    SRCB_FOUR   = 2'b01,
    SRCB_IMM    = 2'b10,
    SRCB_IMM_SH = 2'b11
  } src_b_t;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pc_src_t;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECUTE  = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_ADDIEX   = 4'd10,
    S_ADDIWB   = 4'd11,
    S_JUMP     = 4'd12
  } state_t;

endpackage

// File: rtl/mips_mc_aludec.sv
// mips_mc_aludec
// Combinational R-type funct decoder.
// Ports:
//   funct        in  6  IR[5:0]
//   alu_control  out 3  ALU operation for the funct (add when unsupported)
//   funct_legal  out 1  funct is one of add/sub/and/or/slt

module mips_mc_aludec
  import mips_mc_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_control,
  output logic       funct_legal
);

  // Map each supported funct to its ALU code; anything else is flagged
  // so DECODE can raise illegal instead of entering EXECUTE.
  always_comb begin
    alu_control = ALU_ADD;
    funct_legal = 1'b1;
    case (funct)
      FUNCT_ADD: alu_control = ALU_ADD;
      FUNCT_SUB: alu_control = ALU_SUB;
      FUNCT_AND: alu_control = ALU_AND;
      FUNCT_OR:  alu_control = ALU_OR;
      FUNCT_SLT: alu_control = ALU_SLT;
      default:   funct_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_mc_controller.sv
// mips_mc_controller
// Multi-cycle control FSM for a shared-memory MIPS datapath (one memory
// port for fetch and data). Sequences add/sub/and/or/slt/lw/sw/beq/addi and,
// when MIPS_MC_JUMP_EN is defined, j. Stalls FETCH/MEMREAD/MEMWRITE until
// mem_ready.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   op, funct         latched IR fields
//   zero              ALU zero flag (beq)
//   mem_ready         memory finishes the current access this cycle
//   mem_req, mem_we   memory request / write enable
//   iord              address select (0 PC, 1 ALUOut)
//   ir_we, pc_we      IR / PC load enables
//   reg_we, reg_dst, mem_to_reg   register file write controls
//   alu_src_a, alu_src_b, alu_control  ALU operand/operation selects
//   pc_src            next-PC select
//   retire            pulse on the final cycle of an instruction
//   illegal           pulse when an unsupported instruction is decoded
//   state             current state code (debug)

module mips_mc_controller
  import mips_mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_we,
  output logic       pc_we,
  output logic       reg_we,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [1:0] pc_src,
  output logic       retire,
  output logic       illegal,
  output logic [3:0] state
);

  state_t     state_q;
  state_t     state_d;
  state_t     dec_next;
  logic       dec_illegal;
  logic [2:0] funct_alu;
  logic       funct_legal;

  mips_mc_aludec u_aludec (
    .funct       (funct),
    .alu_control (funct_alu),
    .funct_legal (funct_legal)
  );

  // Opcode dispatch used by DECODE. Unsupported encodings return to FETCH
  // and raise illegal; the PC already advanced during FETCH.
  always_comb begin
    dec_next    = S_FETCH;
    dec_illegal = 1'b0;
    case (op)
      OP_LW, OP_SW: dec_next = S_MEMADR;
      OP_RTYPE: begin
        if (funct_legal) dec_next = S_EXECUTE;
        else             dec_illegal = 1'b1;
      end
      OP_BEQ:  dec_next = S_BRANCH;
      OP_ADDI: dec_next = S_ADDIEX;
      OP_J: begin
`ifdef MIPS_MC_JUMP_EN
        dec_next = S_JUMP;
`else
        dec_illegal = 1'b1;
`endif
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // State register; reset abandons any in-flight access by going to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic. Memory states hold until mem_ready.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_IDLE:     state_d = S_FETCH;
      S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:   state_d = dec_next;
      S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECUTE:  state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_ADDIEX:   state_d = S_ADDIWB;
      S_ADDIWB:   state_d = S_FETCH;
`ifdef MIPS_MC_JUMP_EN
      S_JUMP:     state_d = S_FETCH;
`endif
      default:    state_d = S_FETCH;
    endcase
  end

  // Output decode from the state register. Only the FETCH enables, the
  // sw completion retire, the branch pc_we and the DECODE illegal pulse
  // look at inputs.
  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    iord        = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    reg_we      = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_B;
    alu_control = ALU_ADD;
    pc_src      = PCSRC_ALU;
    retire      = 1'b0;
    illegal     = 1'b0;
    case (state_q)
      S_IDLE: alu_control = ALU_AND;
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_we     = mem_ready;
        pc_we     = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        illegal   = dec_illegal;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWB: begin
        reg_we     = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        retire  = mem_ready;
      end
      S_EXECUTE: begin
        alu_src_a   = 1'b1;
        alu_control = funct_alu;
      end
      S_ALUWB: begin
        reg_we  = 1'b1;
        reg_dst = 1'b1;
        retire  = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        pc_src      = PCSRC_ALUOUT;
        pc_we       = zero;
        retire      = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_ADDIWB: begin
        reg_we = 1'b1;
        retire = 1'b1;
      end
`ifdef MIPS_MC_JUMP_EN
      S_JUMP: begin
        pc_src = PCSRC_JUMP;
        pc_we  = 1'b1;
        retire = 1'b1;
      end
`endif
      default: illegal = 1'b1;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_mips_mc_controller.sv
// tb_mips_mc_controller
// Self-checking bench for mips_mc_controller. An instruction-level model
// expands each instruction (with its memory wait pattern) into the list of
// per-cycle outputs it must produce; a compare process checks the DUT on
// every negative clock edge. Literal state sequences pin the model.
// Honors MIPS_MC_JUMP_EN the same way as the design.

module tb_mips_mc_controller;

  typedef struct packed {
    logic [3:0] st;
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_we;
    logic       pc_we;
    logic       reg_we;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       src_a;
    logic [1:0] src_b;
    logic [2:0] alu;
    logic [1:0] pc_src;
    logic       retire;
    logic       illegal;
  } outs_t;

  typedef struct packed {
    outs_t e;
    logic  rdy;
    logic  z;
  } cyc_t;

`ifdef MIPS_MC_JUMP_EN
  localparam bit JUMP_EN = 1'b1;
`else
  localparam bit JUMP_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_we;
  logic       iord;
  logic       ir_we;
  logic       pc_we;
  logic       reg_we;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_control;
  logic [1:0] pc_src;
  logic       retire;
  logic       illegal;
  logic [3:0] state;

  int          total;
  int          bad;
  cyc_t        q[$];
  outs_t       exp_cur;
  logic        exp_valid;
  string       cur_name;
  logic [63:0] obs_seq;
  int          obs_len;

  mips_mc_controller dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .op          (op),
    .funct       (funct),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .iord        (iord),
    .ir_we       (ir_we),
    .pc_we       (pc_we),
    .reg_we      (reg_we),
    .reg_dst     (reg_dst),
    .mem_to_reg  (mem_to_reg),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_control (alu_control),
    .pc_src      (pc_src),
    .retire      (retire),
    .illegal     (illegal),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares every DUT output bundle against the expected one.
  task automatic checkOutput(input string name, input outs_t exp);
    outs_t act;
    act.st         = state;
    act.mem_req    = mem_req;
    act.mem_we     = mem_we;
    act.iord       = iord;
    act.ir_we      = ir_we;
    act.pc_we      = pc_we;
    act.reg_we     = reg_we;
    act.reg_dst    = reg_dst;
    act.mem_to_reg = mem_to_reg;
    act.src_a      = alu_src_a;
    act.src_b      = alu_src_b;
    act.alu        = alu_control;
    act.pc_src     = pc_src;
    act.retire     = retire;
    act.illegal    = illegal;
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got state=%0d outs=%h, want state=%0d outs=%h",
               name, act.st, act, exp.st, exp);
    end
  endtask

  // Compare process: runs whenever a modelled cycle is in flight.
  always @(negedge clk) begin
    if (exp_valid) checkOutput(cur_name, exp_cur);
  end

  // Quiet outputs for a state: everything 0, ALU add except in IDLE.
  function automatic outs_t blank(input logic [3:0] st);
    outs_t o;
    o     = '0;
    o.st  = st;
    o.alu = (st == 4'd0) ? 3'b000 : 3'b010;
    return o;
  endfunction

  // {legal, alu code} for an R-type funct.
  function automatic logic [3:0] r_alu(input logic [5:0] f);
    case (f)
      6'b100000: return 4'b1010;
      6'b100010: return 4'b1110;
      6'b100100: return 4'b1000;
      6'b100101: return 4'b1001;
      6'b101010: return 4'b1111;
      default:   return 4'b0010;
    endcase
  endfunction

  task automatic push(input outs_t e, input logic rdy, input logic z);
    cyc_t c;
    c.e   = e;
    c.rdy = rdy;
    c.z   = z;
    q.push_back(c);
  endtask

  // Instruction-level model: fw wait cycles in FETCH, mw wait cycles in
  // the data access, zero flag z held for the whole instruction.
  task automatic model_instr(input logic [5:0] o, input logic [5:0] f,
                             input logic z, input int fw, input int mw);
    outs_t e;
    outs_t dec;
    logic [3:0] ra;
    for (int i = 0; i < fw; i++) begin
      e = blank(4'd1); e.mem_req = 1'b1; e.src_b = 2'b01;
      push(e, 1'b0, z);
    end
    e = blank(4'd1); e.mem_req = 1'b1; e.src_b = 2'b01;
    e.ir_we = 1'b1; e.pc_we = 1'b1;
    push(e, 1'b1, z);
    dec = blank(4'd2); dec.src_b = 2'b11;
    ra = r_alu(f);
    if (o == 6'b100011 || o == 6'b101011) begin
      push(dec, 1'b1, z);
      e = blank(4'd3); e.src_a = 1'b1; e.src_b = 2'b10;
      push(e, 1'b1, z);
      if (o == 6'b100011) begin
        e = blank(4'd4); e.mem_req = 1'b1; e.iord = 1'b1;
        for (int i = 0; i < mw; i++) push(e, 1'b0, z);
        push(e, 1'b1, z);
        e = blank(4'd5); e.reg_we = 1'b1; e.mem_to_reg = 1'b1; e.retire = 1'b1;
        push(e, 1'b1, z);
      end else begin
        e = blank(4'd6); e.mem_req = 1'b1; e.mem_we = 1'b1; e.iord = 1'b1;
        for (int i = 0; i < mw; i++) push(e, 1'b0, z);
        e.retire = 1'b1;
        push(e, 1'b1, z);
      end
    end else if (o == 6'b000000 && ra[3]) begin
      push(dec, 1'b1, z);
      e = blank(4'd7); e.src_a = 1'b1; e.alu = ra[2:0];
      push(e, 1'b1, z);
      e = blank(4'd8); e.reg_we = 1'b1; e.reg_dst = 1'b1; e.retire = 1'b1;
      push(e, 1'b1, z);
    end else if (o == 6'b000100) begin
      push(dec, 1'b1, z);
      e = blank(4'd9); e.src_a = 1'b1; e.alu = 3'b110; e.pc_src = 2'b01;
      e.pc_we = z; e.retire = 1'b1;
      push(e, 1'b1, z);
    end else if (o == 6'b001000) begin
      push(dec, 1'b1, z);
      e = blank(4'd10); e.src_a = 1'b1; e.src_b = 2'b10;
      push(e, 1'b1, z);
      e = blank(4'd11); e.reg_we = 1'b1; e.retire = 1'b1;
      push(e, 1'b1, z);
    end else if (o == 6'b000010 && JUMP_EN) begin
      push(dec, 1'b1, z);
      e = blank(4'd12); e.pc_src = 2'b10; e.pc_we = 1'b1; e.retire = 1'b1;
      push(e, 1'b1, z);
    end else begin
      dec.illegal = 1'b1;
      push(dec, 1'b1, z);
    end
  endtask

  // Plays the queued cycles; inputs change 1 time unit after posedge.
  task automatic applyStimulus();
    cyc_t c;
    while (q.size() > 0) begin
      c         = q.pop_front();
      mem_ready = c.rdy;
      zero      = c.z;
      exp_cur   = c.e;
      exp_valid = 1'b1;
      @(negedge clk);
      obs_seq = {obs_seq[59:0], state};
      obs_len++;
      @(posedge clk);
      #1;
    end
    exp_valid = 1'b0;
  endtask

  task automatic run_instr(input string name, input logic [5:0] o,
                           input logic [5:0] f, input logic z,
                           input int fw, input int mw);
    cur_name = name;
    op       = o;
    funct    = f;
    obs_seq  = '0;
    obs_len  = 0;
    model_instr(o, f, z, fw, mw);
    applyStimulus();
  endtask

  // Literal state sequence for the last instruction, one nibble per cycle.
  task automatic checkStates(input string name, input int len, input logic [63:0] seq);
    total++;
    if (obs_len != len || obs_seq !== seq) begin
      bad++;
      $display("[TB] FAIL %s: got len=%0d seq=%h, want len=%0d seq=%h",
               name, obs_len, obs_seq, len, seq);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    op        = 6'b0;
    funct     = 6'b0;
    zero      = 1'b0;
    mem_ready = 1'b0;
    exp_valid = 1'b0;
    exp_cur   = '0;
    total     = 0;
    bad       = 0;
    obs_seq   = '0;
    obs_len   = 0;
    cur_name  = "init";

    #1;
    checkOutput("reset_init", blank(4'd0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cur_name = "idle";
    push(blank(4'd0), 1'b0, 1'b0);
    applyStimulus();

    run_instr("add", 6'b000000, 6'b100000, 1'b0, 0, 0);
    checkStates("add_states", 4, 64'h1278);
    run_instr("sub", 6'b000000, 6'b100010, 1'b0, 0, 0);
    run_instr("and", 6'b000000, 6'b100100, 1'b0, 0, 0);
    run_instr("or",  6'b000000, 6'b100101, 1'b0, 0, 0);
    run_instr("slt", 6'b000000, 6'b101010, 1'b1, 0, 0);

    run_instr("lw_wait", 6'b100011, 6'b000000, 1'b0, 0, 2);
    checkStates("lw_states", 7, 64'h1234445);
    run_instr("lw", 6'b100011, 6'b111111, 1'b0, 0, 0);
    checkStates("lw_fast_states", 5, 64'h12345);
    run_instr("sw_wait", 6'b101011, 6'b000000, 1'b0, 0, 1);
    checkStates("sw_states", 5, 64'h12366);
    run_instr("sw", 6'b101011, 6'b000000, 1'b0, 0, 0);

    run_instr("addi_fwait", 6'b001000, 6'b000000, 1'b0, 2, 0);
    checkStates("addi_states", 6, 64'h1112AB);

    run_instr("beq_taken", 6'b000100, 6'b000000, 1'b1, 0, 0);
    checkStates("beq_states", 3, 64'h129);
    run_instr("beq_not", 6'b000100, 6'b000000, 1'b0, 0, 0);

    run_instr("bad_op", 6'b111111, 6'b100000, 1'b0, 0, 0);
    checkStates("bad_op_states", 2, 64'h12);
    run_instr("bad_funct", 6'b000000, 6'b000000, 1'b0, 0, 0);
    checkStates("bad_funct_states", 2, 64'h12);

    run_instr("jump", 6'b000010, 6'b000000, 1'b0, 0, 0);
    if (JUMP_EN) checkStates("jump_states", 3, 64'h12C);
    else         checkStates("jump_states", 2, 64'h12);

    // lw stalled in MEMREAD, then reset lands mid-cycle.
    cur_name = "lw_abort";
    op       = 6'b100011;
    funct    = 6'b000000;
    model_instr(6'b100011, 6'b000000, 1'b0, 0, 2);
    void'(q.pop_back());
    void'(q.pop_back());
    applyStimulus();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("reset_async", blank(4'd0));
    @(posedge clk);
    #1;
    checkOutput("reset_hold", blank(4'd0));
    rst_n = 1'b1;
    cur_name = "idle2";
    push(blank(4'd0), 1'b0, 1'b0);
    applyStimulus();
    run_instr("add_after_reset", 6'b000000, 6'b100000, 1'b0, 1, 0);
    checkStates("add_after_reset_states", 5, 64'h11278);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_mc_controller.md
# mips_mc_controller

Multi-cycle control FSM that sequences a shared-memory MIPS datapath: one memory port for both instruction fetch and data access, plus IR, A/B, ALUOut and Data registers. It replaces the single-cycle combinational control unit. It decodes the latched opcode/funct, drives every mux select and write enable for each step, and stalls on a memory ready handshake. Supported instructions: add, sub, and, or, slt, lw, sw, beq, addi and (optionally) j.

## Interface
Parameters
- none; all encodings come from the shared package.

Ports
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous reset, active low
- op  in  6  IR[31:26], valid from DECODE onward
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag, combinational
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  memory write enable
- iord  out  1  address select: 0 = PC, 1 = ALUOut
- ir_we  out  1  IR load enable
- pc_we  out  1  PC load enable
- reg_we  out  1  register file write enable
- reg_dst  out  1  write register select: 0 = rt, 1 = rd
- mem_to_reg  out  1  write data select: 0 = ALUOut, 1 = Data
- alu_src_a  out  1  0 = PC, 1 = A
- alu_src_b  out  2  00 = B, 01 = const 4, 10 = SignImm, 11 = SignImm<<2
- alu_control  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- pc_src  out  2  00 = ALUResult, 01 = ALUOut, 10 = jump target
- retire  out  1  one-cycle pulse on the final cycle of each instruction
- illegal  out  1  one-cycle pulse when an unsupported opcode/funct is detected
- state  out  4  current state (debug)

## Operation
- Moore FSM. Outputs decode from the state register, except that ir_we, pc_we, mem_we-completion and retire are gated by mem_ready or zero where stated.
- Unlisted outputs are 0. alu_control defaults to 010 in every state except IDLE, where it is 000.
- IDLE (0): all outputs 0. Next state is FETCH.
- FETCH (1): mem_req, iord=0, alu_src_a=0, alu_src_b=01, pc_src=00, ir_we=pc_we=mem_ready. Stay while mem_ready=0. Otherwise go to DECODE.
- DECODE (2): alu_src_a=0, alu_src_b=11 (branch target into ALUOut). Next state by op:
  - 100011 or 101011 → MEMADR
  - 000000 with legal funct → EXECUTE
  - 000100 → BRANCH
  - 001000 → ADDIEX
  - 000010 → JUMP
  - anything else → illegal=1, next state FETCH
- MEMADR (3): alu_src_a=1, alu_src_b=10. Next state: lw → MEMREAD, sw → MEMWRITE.
- MEMREAD (4): mem_req, iord=1. Stay until mem_ready, then go to MEMWB.
- MEMWB (5): reg_we, reg_dst=0, mem_to_reg=1, retire. Next state FETCH.
- MEMWRITE (6): mem_req, mem_we, iord=1. retire=mem_ready. Stay until mem_ready, then go to FETCH.
- EXECUTE (7): alu_src_a=1, alu_src_b=00. alu_control from funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt. Next state ALUWB.
- ALUWB (8): reg_we, reg_dst=1, mem_to_reg=0, retire. Next state FETCH.
- BRANCH (9): alu_src_a=1, alu_src_b=00, alu_control=110, pc_src=01, pc_we=zero, retire. Next state FETCH.
- ADDIEX (10): alu_src_a=1, alu_src_b=10. Next state ADDIWB.
- ADDIWB (11): reg_we, reg_dst=0, mem_to_reg=0, retire. Next state FETCH.
- JUMP (12): pc_src=10, pc_we, retire. Next state FETCH.
- Codes 13–15 are unreachable. If reached, the FSM goes to FETCH with illegal=1.

## Timing
- rst_n low: state becomes IDLE immediately, asynchronously, and all outputs go to 0 without waiting for clk. An in-flight memory access is abandoned; the controller never re-asserts mem_req for it.
- First rising edge after rst_n rises: IDLE → FETCH.
- Cycles per instruction with mem_ready held at 1, counted from FETCH entry:
  - beq and j: 3
  - R-type, addi and sw: 4
  - lw: 5
- Each cycle with mem_ready low in FETCH, MEMREAD or MEMWRITE adds one cycle.
- mem_req and mem_we are held stable for the whole wait.
- If mem_ready is already high in the first cycle of a memory state, the access completes in that cycle.
- An illegal instruction takes 2 cycles: FETCH, DECODE, then back to FETCH. The PC has already advanced by 4 in FETCH.
- retire and illegal are never asserted in the same cycle.

## Configuration
- MIPS_MC_JUMP_EN defined: op 000010 is decoded and the JUMP state exists.
- MIPS_MC_JUMP_EN undefined: op 000010 is illegal (illegal pulse, back to FETCH), pc_src never takes the value 10, and state 12 is unreachable.

## Structure
- Shared package mips_mc_pkg holds:
  - the opcode and funct constants
  - the alu_control encodings
  - the alu_src_b and pc_src encodings
  - the 4-bit state codes
- One sub-module, mips_mc_aludec: combinational funct → {alu_control, funct_legal}. It is used in EXECUTE and for the legality check in DECODE.

## Test plan
- Reset: rst_n=0 mid-MEMREAD → all outputs 0 and state=0 immediately. After release, one clk → state=1 with mem_req=1.
- add (op 000000, funct 100000), mem_ready=1 → states 1,2,7,8. alu_control=010 in EXECUTE. reg_we=1, reg_dst=1 and retire=1 in cycle 4.
- lw with mem_ready low for 2 cycles in MEMREAD → 7 cycles total. mem_req and iord stay 1 throughout the wait. MEMWB has mem_to_reg=1.
- beq with zero=1 and then zero=0 → pc_we=1 and pc_src=01 in BRANCH for the first. For the second, pc_we=0 and retire=1.
- Unknown op 111111 and R-type funct 000000 → each gives illegal=1 in DECODE, next state 1, and no reg_we or mem_we asserted.
- j (op 000010) → with MIPS_MC_JUMP_EN: states 1,2,12 with pc_src=10 and pc_we=1. Without it: illegal=1.
